// File: rtl/alarm_clock_pkg.sv
// Shared types, limits and time arithmetic for the alarm clock core.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } ring_state_t;

  localparam logic [5:0] MIN_MAX     = 6'd59;
  localparam logic [4:0] HR_MAX      = 5'd23;
  localparam int         MIN_PER_DAY = 1440;

  // Returns {hh, mm} of hh:mm + n minutes, wrapped around midnight.
  function automatic logic [10:0] add_minutes(input logic [4:0] hh,
                                              input logic [5:0] mm,
                                              input int         n);
    int t;
    t = (int'(hh) * 60 + int'(mm) + n) % MIN_PER_DAY;
    return {5'(t / 60), 6'(t % 60)};
  endfunction

endpackage

// File: rtl/hhmm_counter.sv
// hh:mm register with button increments (no cross carry) and a carry-in
// that advances minutes with rollover into hours.
module hhmm_counter
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       carry_in,
  output logic [5:0] mm,
  output logic [4:0] hh
);

  logic [5:0] mm_d, mm_q;
  logic [4:0] hh_d, hh_q;

  always_comb begin
    mm_d = mm_q;
    hh_d = hh_q;
    if (carry_in) begin
      if (mm_q == MIN_MAX) begin
        mm_d = '0;
        hh_d = (hh_q == HR_MAX) ? '0 : hh_q + 5'd1;
      end else begin
        mm_d = mm_q + 6'd1;
      end
    end else begin
      if (inc_min) mm_d = (mm_q == MIN_MAX) ? '0 : mm_q + 6'd1;
      if (inc_hr)  hh_d = (hh_q == HR_MAX) ? '0 : hh_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_q <= '0;
      hh_q <= '0;
    end else begin
      mm_q <= mm_d;
      hh_q <= hh_d;
    end
  end

  assign mm = mm_q;
  assign hh = hh_q;

endmodule

// File: rtl/alarm_clock_core.sv
// 24-hour clock with N_ALARMS armed alarm slots and a ring state machine.
// Snooze is compiled in only when ALARM_SNOOZE_EN is defined.
//
// state   | meaning
// IDLE    | nothing ringing, waiting for an alarm match
// RINGING | alarm active, counting minute rollovers towards auto-stop
// SNOOZE  | ring suspended until the snooze target minute
module alarm_clock_core
  import alarm_clock_pkg::*;
#(
  parameter  int N_ALARMS         = 4,
  parameter  int RING_TIMEOUT_MIN = 10,
  parameter  int SNOOZE_MIN       = 5,
  localparam int AW               = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sec_tick,
  input  logic                power,
  input  logic                set_time,
  input  logic                set_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic                inc_min,
  input  logic                inc_hr,
  input  logic [N_ALARMS-1:0] alarm_arm,
  input  logic                mute,
  input  logic                stop,
  input  logic                snooze,
  output logic [5:0]          seconds,
  output logic [5:0]          minutes,
  output logic [4:0]          hours,
  output logic [5:0]          disp_min,
  output logic [4:0]          disp_hr,
  output logic                buzzer,
  output logic                ringing,
  output logic [AW-1:0]       ring_id,
  output logic                led_set_time,
  output logic                led_set_alarm
);

  localparam int BTN_INC_MIN = 0;
  localparam int BTN_INC_HR  = 1;
  localparam int BTN_STOP    = 2;
  localparam int BTN_SNOOZE  = 3;

  logic [3:0]          btn_d, btn_q, edge_d, edge_q;
  logic [5:0]          sec_d, sec_q;
  logic                adv_d, adv_q;
  logic                alarm_mode, run_mode, min_carry, minute_evt;
  logic [5:0]          time_mm;
  logic [4:0]          time_hh;
  logic [5:0]          al_mm [N_ALARMS];
  logic [4:0]          al_hh [N_ALARMS];
  logic [N_ALARMS-1:0] al_inc_min, al_inc_hr;
  logic                match_any;
  logic [AW-1:0]       match_idx;
  ring_state_t         state_d, state_q;
  logic [5:0]          tmo_d, tmo_q;
  logic [AW-1:0]       ring_id_d, ring_id_q;
  logic                led_time_d, led_time_q, led_alarm_d, led_alarm_q;

`ifdef ALARM_SNOOZE_EN
  logic [5:0] snz_mm_d, snz_mm_q;
  logic [4:0] snz_hh_d, snz_hh_q;
`else
  logic unused_snooze;
  assign unused_snooze = edge_q[BTN_SNOOZE] ^ (SNOOZE_MIN != 0);
`endif

  always_comb begin
    btn_d  = {snooze, stop, inc_hr, inc_min};
    edge_d = btn_d & ~btn_q;
  end

  // Previous levels reset high so a button held through reset never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q  <= '1;
      edge_q <= '0;
    end else begin
      btn_q  <= btn_d;
      edge_q <= edge_d;
    end
  end

  always_comb begin
    alarm_mode  = set_alarm & ~set_time;
    run_mode    = ~set_time & ~set_alarm;
    adv_d       = power & sec_tick & ~set_time;
    min_carry   = adv_d & (sec_q == MIN_MAX);
    minute_evt  = adv_q & (sec_q == '0);
    led_time_d  = set_time;
    led_alarm_d = alarm_mode;
    sec_d       = sec_q;
    if (set_time)   sec_d = '0;
    else if (adv_d) sec_d = (sec_q == MIN_MAX) ? '0 : sec_q + 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q       <= '0;
      adv_q       <= 1'b0;
      led_time_q  <= 1'b0;
      led_alarm_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      adv_q       <= adv_d;
      led_time_q  <= led_time_d;
      led_alarm_q <= led_alarm_d;
    end
  end

  hhmm_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .inc_min  (edge_q[BTN_INC_MIN] & set_time),
    .inc_hr   (edge_q[BTN_INC_HR] & set_time),
    .carry_in (min_carry),
    .mm       (time_mm),
    .hh       (time_hh)
  );

  always_comb begin
    al_inc_min = '0;
    al_inc_hr  = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (alarm_mode && alarm_sel == i[AW-1:0]) begin
        al_inc_min[i] = edge_q[BTN_INC_MIN];
        al_inc_hr[i]  = edge_q[BTN_INC_HR];
      end
    end
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_alarm
    hhmm_counter u_alarm (
      .clk      (clk),
      .rst      (rst),
      .inc_min  (al_inc_min[g]),
      .inc_hr   (al_inc_hr[g]),
      .carry_in (1'b0),
      .mm       (al_mm[g]),
      .hh       (al_hh[g])
    );
  end

  // Scan from the top so the lowest matching slot wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (alarm_arm[i] && al_mm[i] == time_mm && al_hh[i] == time_hh) begin
        match_any = 1'b1;
        match_idx = i[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      ring_id_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      ring_id_q <= ring_id_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snz_mm_q <= '0;
      snz_hh_q <= '0;
    end else begin
      snz_mm_q <= snz_mm_d;
      snz_hh_q <= snz_hh_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    ring_id_d = ring_id_q;
`ifdef ALARM_SNOOZE_EN
    snz_mm_d  = snz_mm_q;
    snz_hh_d  = snz_hh_q;
`endif
    case (state_q)
      IDLE: begin
        if (match_any && minute_evt && run_mode && power) begin
          state_d   = RINGING;
          ring_id_d = match_idx;
          tmo_d     = 6'(RING_TIMEOUT_MIN);
        end
      end
      RINGING: begin
        if (!power || edge_q[BTN_STOP]) begin
          state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (edge_q[BTN_SNOOZE]) begin
          state_d              = SNOOZE;
          {snz_hh_d, snz_mm_d} = add_minutes(time_hh, time_mm, SNOOZE_MIN);
`endif
        end else if (minute_evt) begin
          if (tmo_q <= 6'd1) state_d = IDLE;
          else               tmo_d   = tmo_q - 6'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!power || edge_q[BTN_STOP]) begin
          state_d = IDLE;
        end else if (minute_evt && time_hh == snz_hh_q && time_mm == snz_mm_q) begin
          state_d = RINGING;
          tmo_d   = 6'(RING_TIMEOUT_MIN);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ringing = (state_q == RINGING);
    buzzer  = ringing & ~mute & power;
  end

  always_comb begin
    disp_min = time_mm;
    disp_hr  = time_hh;
    if (alarm_mode) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (alarm_sel == i[AW-1:0]) begin
          disp_min = al_mm[i];
          disp_hr  = al_hh[i];
        end
      end
    end
  end

  assign seconds       = sec_q;
  assign minutes       = time_mm;
  assign hours         = time_hh;
  assign ring_id       = ring_id_q;
  assign led_set_time  = led_time_q;
  assign led_set_alarm = led_alarm_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed and randomized checks of alarm_clock_core against a seconds-of-day model.
module tb_alarm_clock_core;

  localparam int N   = 4;
  localparam int TMO = 10;
  localparam int SNZ = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sec_tick, power, set_time, set_alarm;
  logic [1:0]   alarm_sel;
  logic         inc_min, inc_hr, mute, stop, snooze;
  logic [N-1:0] alarm_arm;
  logic [5:0]   seconds, minutes, disp_min;
  logic [4:0]   hours, disp_hr;
  logic         buzzer, ringing, led_set_time, led_set_alarm;
  logic [1:0]   ring_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds of day, alarms as minutes of day.
  int m_t;
  int m_al [N];
  bit m_ringing, m_snoozed;
  int m_id, m_rolls, m_snz_min;

  alarm_clock_core #(.N_ALARMS(N), .RING_TIMEOUT_MIN(TMO), .SNOOZE_MIN(SNZ)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .power(power), .set_time(set_time),
    .set_alarm(set_alarm), .alarm_sel(alarm_sel), .inc_min(inc_min), .inc_hr(inc_hr),
    .alarm_arm(alarm_arm), .mute(mute), .stop(stop), .snooze(snooze),
    .seconds(seconds), .minutes(minutes), .hours(hours), .disp_min(disp_min),
    .disp_hr(disp_hr), .buzzer(buzzer), .ringing(ringing), .ring_id(ring_id),
    .led_set_time(led_set_time), .led_set_alarm(led_set_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_t = 0;
    m_ringing = 0;
    m_snoozed = 0;
    m_id = 0;
    m_rolls = 0;
    for (int i = 0; i < N; i++) m_al[i] = 0;
  endtask

  task automatic model_tick();
    int nm;
    if (!power || set_time) return;
    m_t = (m_t + 1) % 86400;
    if (m_t % 60 != 0) return;
    nm = m_t / 60;
    if (m_ringing) begin
      m_rolls++;
      if (m_rolls >= TMO) m_ringing = 0;
    end else if (m_snoozed) begin
      if (nm == m_snz_min) begin
        m_snoozed = 0;
        m_ringing = 1;
        m_rolls = 0;
      end
    end else if (!set_alarm) begin
      for (int i = 0; i < N; i++) begin
        if (alarm_arm[i] && m_al[i] == nm) begin
          m_ringing = 1;
          m_id = i;
          m_rolls = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_time(input string tag);
    chk({tag, "_sec"}, seconds, m_t % 60);
    chk({tag, "_min"}, minutes, (m_t / 60) % 60);
    chk({tag, "_hr"},  hours,   m_t / 3600);
    if (!set_alarm) begin
      chk({tag, "_disp_min"}, disp_min, (m_t / 60) % 60);
      chk({tag, "_disp_hr"},  disp_hr,  m_t / 3600);
    end
  endtask

  task automatic check_ring(input string tag);
    chk({tag, "_ringing"}, ringing, m_ringing);
    if (m_ringing) chk({tag, "_ring_id"}, ring_id, m_id);
    chk({tag, "_buzzer"}, buzzer, m_ringing && !mute && power);
  endtask

  task automatic tick();
    bit prev;
    prev = m_ringing;
    sec_tick = 1; step(); sec_tick = 0;
    model_tick();
    check_time("tick");
    chk("tick_ring_lat", ringing, prev);
    step();
    check_ring("tick");
  endtask

  task automatic press(input int which);
    case (which)
      0: inc_min = 1;
      1: inc_hr  = 1;
      2: stop    = 1;
      default: snooze = 1;
    endcase
    step(); step();
    inc_min = 0; inc_hr = 0; stop = 0; snooze = 0;
    step();
  endtask

  task automatic set_time_to(input int hh, input int mm);
    set_time = 1; step();
    m_t = m_t - m_t % 60;
    chk("set_time_led", led_set_time, 1);
    chk("set_time_sec0", seconds, 0);
    repeat ((hh - m_t / 3600 + 24) % 24) press(1);
    repeat ((mm - (m_t / 60) % 60 + 60) % 60) press(0);
    m_t = hh * 3600 + mm * 60;
    set_time = 0; step();
    check_time("set_time");
  endtask

  task automatic set_slot(input int s, input int hh, input int mm);
    set_alarm = 1; alarm_sel = 2'(s); step();
    repeat ((hh - m_al[s] / 60 + 24) % 24) press(1);
    repeat ((mm - m_al[s] % 60 + 60) % 60) press(0);
    m_al[s] = hh * 60 + mm;
    chk("slot_disp_hr",  disp_hr,  hh);
    chk("slot_disp_min", disp_min, mm);
    chk("slot_led", led_set_alarm, 1);
    set_alarm = 0; #1;
    chk("slot_disp_back", disp_min, (m_t / 60) % 60);
    step();
  endtask

  task automatic stop_ring();
    bit was;
    was = m_ringing;
    stop = 1; step();
    chk("stop_lat1", ringing, was);
    step();
    m_ringing = 0; m_snoozed = 0;
    check_ring("stop");
    stop = 0; step();
  endtask

  initial begin
    int s, hh, mm, start, arm;
    rst = 1; sec_tick = 0; power = 1; set_time = 0; set_alarm = 0; alarm_sel = '0;
    inc_min = 1; inc_hr = 0; mute = 0; stop = 0; snooze = 0; alarm_arm = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sec", seconds, 0);
    chk("rst_min", minutes, 0);
    chk("rst_hr", hours, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_ring_id", ring_id, 0);
    chk("rst_led_t", led_set_time, 0);
    chk("rst_led_a", led_set_alarm, 0);
    rst = 0; step(); step();
    inc_min = 0; step(); step();
    chk("held_btn_min", minutes, 0);

    // 60 ticks to 00:01:00, then the midnight wrap.
    repeat (60) tick();
    chk("t60_min", minutes, 1);
    chk("t60_sec", seconds, 0);
    set_time_to(23, 59);
    repeat (59) tick();
    tick();
    chk("midnight", {hours, minutes, seconds}, 17'd0);
    step();
    chk("midnight_hold", {hours, minutes, seconds}, 17'd0);

    // Single alarm on slot 2 with mute.
    set_slot(2, 6, 30);
    alarm_arm = 4'b0100;
    set_time_to(6, 29);
    repeat (59) tick();
    tick();
    chk("a630_ringing", ringing, 1);
    chk("a630_id", ring_id, 2);
    chk("a630_buzzer", buzzer, 1);
    mute = 1; #1;
    chk("mute_buzzer", buzzer, 0);
    chk("mute_ringing", ringing, 1);
    mute = 0;
    stop_ring();

    // Two slots at 07:00: lowest index rings once.
    set_slot(0, 7, 0);
    set_slot(3, 7, 0);
    alarm_arm = 4'b1101;
    set_time_to(6, 59);
    repeat (60) tick();
    chk("dual_id", ring_id, 0);
    chk("dual_ringing", ringing, 1);
    stop_ring();
    chk("dual_stopped", ringing, 0);

    // Unattended ring times out at the 10th minute rollover.
    set_time_to(6, 59);
    repeat (60) tick();
    for (int k = 0; k < TMO * 60 - 1; k++) tick();
    chk("tmo_before", ringing, 1);
    tick();
    chk("tmo_idle", ringing, 0);

    // Snooze across midnight (no effect when compiled out).
    alarm_arm = 4'b0010;
    set_slot(1, 23, 58);
    set_time_to(23, 57);
    repeat (60) tick();
    chk("snz_ring", ringing, 1);
    press(3);
    if (SNZ_EN && m_ringing) begin
      m_ringing = 0;
      m_snoozed = 1;
      m_snz_min = (m_t / 60 + SNZ) % 1440;
    end
    check_ring("snz_press");
    chk("snooze_press", ringing, SNZ_EN ? 0 : 1);
    for (int k = 0; k < 400 && m_t != 180; k++) tick();
    chk("snooze_rering", ringing, 1);
    chk("snooze_time", {hours, minutes, seconds}, {5'd0, 6'd3, 6'd0});
    stop_ring();

    // Randomized alarm times, arm masks and mute.
    for (int it = 0; it < 5; it++) begin
      s  = $urandom_range(0, N - 1);
      hh = $urandom_range(0, 23);
      mm = $urandom_range(0, 59);
      arm = $urandom_range(0, 15) | (1 << s);
      set_slot(s, hh, mm);
      alarm_arm = 4'(arm);
      start = (hh * 60 + mm + 1439) % 1440;
      set_time_to(start / 60, start % 60);
      repeat (60 + $urandom_range(0, 20)) begin
        mute = 1'($urandom_range(0, 1));
        tick();
      end
      mute = 0;
      stop_ring();
    end

    // Power off during a ring, then async reset during a ring.
    alarm_arm = 4'b1000;
    set_slot(3, 8, 15);
    set_time_to(8, 14);
    repeat (60) tick();
    chk("pwr_ring", ringing, 1);
    power = 0; #1;
    chk("pwr_buzzer", buzzer, 0);
    step();
    m_ringing = 0; m_snoozed = 0;
    chk("pwr_idle", ringing, 0);
    tick();
    chk("pwr_frozen", {hours, minutes, seconds}, {5'd8, 6'd15, 6'd0});
    power = 1; step();

    set_time_to(8, 14);
    repeat (60) tick();
    chk("rst_ring_pre", ring_id, 3);
    set_alarm = 1; step();
    chk("rst_led_pre", led_set_alarm, 1);
    #2; rst = 1; #1;
    chk("arst_ringing", ringing, 0);
    chk("arst_buzzer", buzzer, 0);
    chk("arst_ring_id", ring_id, 0);
    chk("arst_led_a", led_set_alarm, 0);
    chk("arst_time", {hours, minutes, seconds}, 17'd0);
    model_reset();
    set_alarm = 0; alarm_arm = '0;
    step();
    rst = 0; step();
    tick();
    chk("post_rst_tick", seconds, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
